// File: rtl/alu_mul_seq.sv
// Sequential 32x32 unsigned shift-add multiplier that borrows an external shared ALU
// for its per-iteration addition; 32 RUN cycles, then a one-cycle done pulse.
module alu_mul_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic        busy,
    output logic        done,
    output logic [63:0] product,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic        alu_cout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [4:0]  r_cnt;
    logic        r_c;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_mc;
    logic [63:0] r_product;
    logic [31:0] w_hi_nxt;
    logic [31:0] w_lo_nxt;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        alu_src1    = '0;
        alu_src2    = '0;
        alu_ctrl    = 4'b0000;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                busy     = 1'b1;
                alu_src1 = r_hi;
                alu_src2 = r_mc;
                alu_ctrl = 4'b0010;
                if (r_cnt == 5'd31) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // 65-bit right shift of {c, hi, lo}; c is the top bit of the accumulator and is
    // always zero between iterations, so the non-add path shifts it in unchanged.
    always_comb begin
        if (r_lo[0]) {w_hi_nxt, w_lo_nxt} = {alu_cout, alu_result, r_lo[31:1]};
        else         {w_hi_nxt, w_lo_nxt} = {r_c, r_hi, r_lo[31:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_c       <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_mc      <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mc  <= mcand;
                        r_hi  <= '0;
                        r_c   <= 1'b0;
                        r_lo  <= mplier;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_c   <= 1'b0;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) r_product <= {w_hi_nxt, w_lo_nxt};
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 The block SHALL have exactly one clock and one reset; reset is synchronous and active-high.
REQ-002 The block SHALL have these ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- start  input  1  request a multiply; sampled only in IDLE
- mcand  input  32  multiplicand, unsigned, sampled with start
- mplier  input  32  multiplier, unsigned, sampled with start
- busy  output  1  high while a multiply is in progress (RUN and DONE)
- done  output  1  one-cycle pulse; product valid
- product  output  64  unsigned product, held until the next accepted start or reset
- alu_src1  output  32  to the shared ALU src1
- alu_src2  output  32  to the shared ALU src2
- alu_ctrl  output  4  to the shared ALU control; bit3 A_invert, bit2 B_invert, bits1:0 operation
- alu_result  input  32  from the ALU, combinational from alu_src1/alu_src2/alu_ctrl
- alu_cout  input  1  ALU carry out
REQ-003 The block SHALL ignore the ALU zero and overflow outputs.

Function
REQ-004 The block SHALL be an FSM with states IDLE, RUN and DONE, plus a 5-bit iteration counter cnt.
REQ-005 It SHALL hold a 65-bit accumulator {c, hi[31:0], lo[31:0]} and a 32-bit multiplicand register mc.
REQ-006 IDLE with start=1 SHALL, on the clock edge, load:
- mc <= mcand
- hi <= 0
- c <= 0
- lo <= mplier
- cnt <= 0
- state -> RUN
REQ-007 IDLE with start=0 SHALL hold all registers.
REQ-008 In RUN the block SHALL drive alu_src1=hi, alu_src2=mc and alu_ctrl=4'b0010 (add, no inversion, carry-in 0).
REQ-009 In IDLE and DONE the block SHALL drive alu_src1=0, alu_src2=0 and alu_ctrl=4'b0000.
REQ-010 Each RUN cycle with lo[0]=1 SHALL update {hi, lo} <= {alu_cout, alu_result, lo[31:1]}, i.e. a 65-bit right shift of {cout, sum, lo}.
REQ-011 Each RUN cycle with lo[0]=0 SHALL update {hi, lo} <= {1'b0, hi, lo[31:1]}.
REQ-012 In RUN, c SHALL always be cleared after the shift, and cnt SHALL increment every RUN cycle, wrapping 31->0.
REQ-013 A RUN cycle with cnt=31 SHALL perform its final iteration and go to DONE; RUN therefore lasts exactly 32 cycles.
REQ-014 In DONE, done=1 for exactly one cycle and the state SHALL return to IDLE on the next edge.
REQ-015 product SHALL equal {hi, lo}, registered, and be valid from the DONE cycle onward.
REQ-016 Latency: done SHALL be high in the 33rd cycle after the edge that accepted start.
REQ-017 start asserted in RUN or DONE SHALL be ignored and not queued; the first accepting edge is the IDLE cycle after DONE.
REQ-018 mcand and mplier changes after acceptance SHALL NOT affect the result.
REQ-019 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-020 Arithmetic SHALL be unsigned, and the full 64-bit result SHALL be exact for all operands, including 0 and 0xFFFFFFFF.

Reset
REQ-021 rst=1 at an edge SHALL force state=IDLE and clear cnt, c, hi, lo, mc and product to 0, with busy=0 and done=0, regardless of state.
REQ-022 rst SHALL take priority over start in the same cycle.
REQ-023 An operation interrupted by reset SHALL be discarded and SHALL NOT produce done.

Verification
REQ-024 The bench SHALL connect the block to a behavioural 32-bit adder ALU model (result, cout) and cover these scenarios:
- Reset, then start with mcand=3, mplier=5 -> done pulses exactly 33 cycles after the accepting edge; product=64'h0000_0000_0000_000F; busy high 33 cycles.
- mcand=mplier=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001; intermediate carries are exercised via alu_cout.
- mcand=32'h1234_5678, mplier=0 -> product=0; alu_ctrl=4'b0010 throughout RUN and 4'b0000 in IDLE/DONE.
- start held high continuously with operands 7x9 then 2x2 -> first product=63 and second=4; the second is accepted only in the IDLE cycle after DONE; no start is accepted in RUN or DONE.
- rst pulsed at RUN cycle 10 -> next cycle is IDLE with product=0 and busy=0; no done pulse follows; a new start of 6x7 yields 42.
- 1000 random operand pairs compared against a 64-bit reference multiply -> zero mismatches.
